// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one
// input bit per clock. Turns binary game counters (score, timer) into per-digit
// BCD nibbles, each nibble driving one 7-segment digit decoder.
//
// Parameters:
//   BIN_W   width of the binary input (1..16)
//   DIGITS  number of BCD digits produced (1..5)
//
// Ports:
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start     in   convert request, accepted only while idle
//   binary    in   value to convert, captured when start is accepted
//   busy      out  conversion in progress
//   done      out  one-cycle pulse: bcd/overflow were updated this cycle
//   bcd       out  result, digit i at bcd[4i+3:4i], digit 0 = ones
//   overflow  out  last accepted value exceeded 10^DIGITS-1 (bcd saturated to 9s)
//
// Optional build macro:
//   BCD_BLANK_EN  leading-zero suppression; zero digits above the most
//                 significant nonzero digit are output as 4'hF. Digit 0 and a
//                 saturated result are never blanked.
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    // Scratch carries one digit more than the output so that values just above
    // the output range are still caught as overflow.
    localparam int SW      = 4 * (DIGITS + 1);
    localparam int CW      = $clog2(BIN_W + 1);
    localparam int MAX_VAL = (10 ** DIGITS) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [BIN_W-1:0]       shreg_q;
    logic [BIN_W-1:0]       value_q;
    logic [SW-1:0]          scratch_q;
    logic [CW-1:0]          count_q;
    logic                   lost_q;
    logic                   busy_q;
    logic                   done_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic                   overflow_q;

    logic [SW-1:0]          adj_d;
    logic [SW-1:0]          scratch_d;
    logic                   ovf_d;
    logic [4*DIGITS-1:0]    result_d;

    // Add-3 correction applied to every scratch digit before each shift.
    generate
        for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
            assign adj_d[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                    ? scratch_q[4*gi +: 4] + 4'd3
                                    : scratch_q[4*gi +: 4];
        end
    endgenerate

    assign scratch_d = {adj_d[SW-2:0], shreg_q[BIN_W-1]};

    // A bit falling off the top of the scratch (only possible for narrow
    // DIGITS vs. wide BIN_W) is remembered via lost_q; the value compare also
    // covers that case, both are kept for robustness.
    assign ovf_d = lost_q
                || (scratch_q[SW-1 -: 4] != 4'd0)
                || (32'(value_q) > 32'(MAX_VAL));

    always_comb begin
        result_d = scratch_q[4*DIGITS-1:0];
        if (ovf_d) begin
            result_d = {DIGITS{4'h9}};
        end
`ifdef BCD_BLANK_EN
        else begin : blank_leading
            logic lead;
            lead = 1'b1;
            // Walk down from the top digit, blanking zeros until the first
            // nonzero digit; digit 0 is always shown.
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (result_d[4*i +: 4] == 4'd0)) begin
                    result_d[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            value_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            lost_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= binary;
                        value_q   <= binary;
                        scratch_q <= '0;
                        lost_q    <= 1'b0;
                        count_q   <= CW'(BIN_W);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shreg_q   <= shreg_q << 1;
                    lost_q    <= lost_q | adj_d[SW-1];
                    count_q   <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q      <= result_d;
                    overflow_q <= ovf_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
